// File: rtl/dmi_pkg.sv
// Shared types and constants for the DMI core-side request controller.
package dmi_pkg;

  localparam int DMI_ADDR_W    = 7;
  localparam int DMI_DATA_W    = 32;
  localparam int DMI_TIMEOUT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } dmi_state_e;

  localparam logic [1:0] DMI_OP_OK     = 2'd0;
  localparam logic [1:0] DMI_OP_FAILED = 2'd2;
  localparam logic [1:0] DMI_OP_BUSY   = 2'd3;

endpackage

// File: rtl/dmi_op_status_reg.sv
// Sticky DMI op status: the first error code is kept until cleared.
// A clear arriving together with a new error loads the new error.
module dmi_op_status_reg
  import dmi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       set_i,
  input  logic [1:0] code_i,
  output logic [1:0] status_o
);

  logic [1:0] status_q, status_d;

  // Next status: set only when currently OK (or being cleared this cycle).
  always_comb begin
    status_d = status_q;
    if (set_i && ((status_q == DMI_OP_OK) || clr_i)) begin
      status_d = code_i;
    end else if (clr_i) begin
      status_d = DMI_OP_OK;
    end
  end

  // Status register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= DMI_OP_OK;
    end else begin
      status_q <= status_d;
    end
  end

  assign status_o = status_q;

endmodule

// File: rtl/dmi_core_req_ctrl.sv
// Core-clock DMI request controller: turns synchronized reg_en pulses into
// one valid/ready request, waits for the response and holds read data and
// sticky op status for the JTAG side.
// Optional response timeout: define DMI_REQ_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for reg_en; request registers hold last access
// ST_REQ  | dmi_req_valid high, waiting for dmi_req_ready
// ST_RSP  | request accepted, waiting for dmi_rsp_valid (or timeout)
module dmi_core_req_ctrl
  import dmi_pkg::*;
#(
  parameter int ADDR_W    = DMI_ADDR_W,
  parameter int DATA_W    = DMI_DATA_W,
  parameter int TIMEOUT_W = DMI_TIMEOUT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_en,
  input  logic              reg_wr_en,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  output logic              dmi_req_valid,
  input  logic              dmi_req_ready,
  output logic              dmi_req_wr,
  output logic [ADDR_W-1:0] dmi_req_addr,
  output logic [DATA_W-1:0] dmi_req_wdata,
  input  logic              dmi_rsp_valid,
  input  logic              dmi_rsp_err,
  input  logic [DATA_W-1:0] dmi_rsp_rdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [1:0]        op_status,
  input  logic              status_clr
);

  dmi_state_e        state_q, state_d;
  logic              req_wr_q, req_wr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rsp_fail;
  logic              overrun;
  logic              err_set;
  logic [1:0]        err_code;

  if (TIMEOUT_W < 1) begin : g_bad_timeout_w
    $error("TIMEOUT_W must be at least 1");
  end

`ifdef DMI_REQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 tmo;

  // Timeout fires on the RSP cycle whose increment would reach all-ones.
  assign cnt_inc = cnt_q + TIMEOUT_W'(1);
  assign tmo     = &cnt_inc;
`endif

  // busy is high on the cycle the FSM returns to IDLE, so reg_en there overruns.
  assign overrun  = reg_en && (state_q != ST_IDLE);
  assign err_set  = rsp_fail || overrun;
  assign err_code = rsp_fail ? DMI_OP_FAILED : DMI_OP_BUSY;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    req_wr_d    = req_wr_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    rd_data_d   = rd_data_q;
    rsp_fail    = 1'b0;
`ifdef DMI_REQ_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (reg_en) begin
          req_wr_d    = reg_wr_en;
          req_addr_d  = reg_addr;
          req_wdata_d = reg_wdata;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
`ifdef DMI_REQ_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (dmi_req_ready) begin
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (dmi_rsp_valid) begin
          if (dmi_rsp_err) begin
            rsp_fail = 1'b1;
          end else if (!req_wr_q) begin
            rd_data_d = dmi_rsp_rdata;
          end
          state_d = ST_IDLE;
        end
`ifdef DMI_REQ_TIMEOUT_EN
        else if (tmo) begin
          rsp_fail = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request/response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rd_data_q   <= '0;
`ifdef DMI_REQ_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      req_wr_q    <= req_wr_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      rd_data_q   <= rd_data_d;
`ifdef DMI_REQ_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  dmi_op_status_reg u_status (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (status_clr),
    .set_i    (err_set),
    .code_i   (err_code),
    .status_o (op_status)
  );

  assign dmi_req_valid = (state_q == ST_REQ);
  assign busy          = (state_q != ST_IDLE);
  assign dmi_req_wr    = req_wr_q;
  assign dmi_req_addr  = req_addr_q;
  assign dmi_req_wdata = req_wdata_q;
  assign rd_data       = rd_data_q;

endmodule

// File: tb/tb_dmi_core_req_ctrl.sv
// Directed bench for dmi_core_req_ctrl: vector table of full transactions
// plus hand sequences for overrun, clear/set collision, reset and timeout.
module tb_dmi_core_req_ctrl;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int TW = 4;

  logic          clk;
  logic          rst_n;
  logic          reg_en, reg_wr_en;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic          dmi_req_valid, dmi_req_ready, dmi_req_wr;
  logic [AW-1:0] dmi_req_addr;
  logic [DW-1:0] dmi_req_wdata;
  logic          dmi_rsp_valid, dmi_rsp_err;
  logic [DW-1:0] dmi_rsp_rdata;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic [1:0]    op_status;
  logic          status_clr;

  int total = 0;
  int bad   = 0;

  dmi_core_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(TW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .reg_en        (reg_en),
    .reg_wr_en     (reg_wr_en),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .dmi_req_valid (dmi_req_valid),
    .dmi_req_ready (dmi_req_ready),
    .dmi_req_wr    (dmi_req_wr),
    .dmi_req_addr  (dmi_req_addr),
    .dmi_req_wdata (dmi_req_wdata),
    .dmi_rsp_valid (dmi_rsp_valid),
    .dmi_rsp_err   (dmi_rsp_err),
    .dmi_rsp_rdata (dmi_rsp_rdata),
    .rd_data       (rd_data),
    .busy          (busy),
    .op_status     (op_status),
    .status_clr    (status_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          clr;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            rdy_dly;
    int            rsp_dly;
    logic          err;
    logic [DW-1:0] rdata;
    logic [DW-1:0] exp_rd;
    logic [1:0]    exp_st;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    chk("status_clr", 32'(op_status), 32'(2'd0));
  endtask

  task automatic start_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    reg_en = 1'b1; reg_wr_en = wr; reg_addr = a; reg_wdata = d;
    tick();
    reg_en = 1'b0; reg_wr_en = 1'b0;
    chk("req_valid_rise", 32'(dmi_req_valid), 32'd1);
    chk("req_addr", 32'(dmi_req_addr), 32'(a));
    chk("req_wr", 32'(dmi_req_wr), 32'(wr));
    chk("req_wdata", dmi_req_wdata, d);
  endtask

  task automatic accept(input int dly, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    dmi_req_ready = 1'b0;
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("hold_valid", 32'(dmi_req_valid), 32'd1);
      chk("hold_addr", 32'(dmi_req_addr), 32'(a));
      chk("hold_wdata", dmi_req_wdata, d);
      chk("hold_wr", 32'(dmi_req_wr), 32'(wr));
    end
    dmi_req_ready = 1'b1;
    tick();
    dmi_req_ready = 1'b0;
    chk("valid_drop", 32'(dmi_req_valid), 32'd0);
    chk("busy_in_rsp", 32'(busy), 32'd1);
  endtask

  task automatic respond(input int dly, input logic err, input logic [DW-1:0] rd);
    for (int i = 1; i < dly; i++) tick();
    dmi_rsp_valid = 1'b1; dmi_rsp_err = err; dmi_rsp_rdata = rd;
    tick();
    dmi_rsp_valid = 1'b0; dmi_rsp_err = 1'b0;
    chk("busy_after_rsp", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; reg_en = 1'b0; reg_wr_en = 1'b0; reg_addr = '0; reg_wdata = '0;
    dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0; dmi_rsp_err = 1'b0; dmi_rsp_rdata = '0;
    status_clr = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 7'h11, 32'h0, 0, 3, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 2'd0};
    vecs[1] = '{1'b0, 1'b1, 7'h10, 32'h0000_0001, 5, 2, 1'b0, 32'hBAD0BAD0, 32'hDEADBEEF, 2'd0};
    vecs[2] = '{1'b0, 1'b0, 7'h22, 32'h0, 1, 1, 1'b1, 32'h12345678, 32'hDEADBEEF, 2'd2};
    vecs[3] = '{1'b0, 1'b0, 7'h05, 32'h0, 0, 2, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 2'd2};
    vecs[4] = '{1'b0, 1'b1, 7'h7F, 32'h8000_0000, 2, 1, 1'b1, 32'h0, 32'hCAFEF00D, 2'd2};
    vecs[5] = '{1'b1, 1'b0, 7'h00, 32'h0, 0, 4, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'd0};

    tick(); tick();
    chk("rst_valid", 32'(dmi_req_valid), 32'd0);
    chk("rst_wr", 32'(dmi_req_wr), 32'd0);
    chk("rst_addr", 32'(dmi_req_addr), 32'd0);
    chk("rst_wdata", dmi_req_wdata, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_status", 32'(op_status), 32'd0);
    rst_n = 1'b1;
    tick();

    // reg_wr_en alone must not start anything
    reg_wr_en = 1'b1;
    tick();
    reg_wr_en = 1'b0;
    chk("wr_en_alone_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].clr) pulse_clr();
      start_req(vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      accept(vecs[v].rdy_dly, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      respond(vecs[v].rsp_dly, vecs[v].err, vecs[v].rdata);
      chk($sformatf("vec%0d_rd_data", v), rd_data, vecs[v].exp_rd);
      chk($sformatf("vec%0d_status", v), 32'(op_status), 32'(vecs[v].exp_st));
    end

    // response strobe while still in REQ is ignored
    start_req(1'b0, 7'h33, 32'h0);
    dmi_rsp_valid = 1'b1; dmi_rsp_rdata = 32'h11111111;
    tick();
    dmi_rsp_valid = 1'b0;
    chk("req_rsp_ignored_valid", 32'(dmi_req_valid), 32'd1);
    chk("req_rsp_ignored_rd", rd_data, 32'hA5A5A5A5);
    accept(0, 1'b0, 7'h33, 32'h0);
    respond(1, 1'b0, 32'h22222222);
    chk("after_req_rsp_rd", rd_data, 32'h22222222);

    // overrun two cycles into REQ
    start_req(1'b0, 7'h44, 32'h0);
    tick();
    reg_en = 1'b1; reg_wr_en = 1'b1; reg_addr = 7'h45; reg_wdata = 32'hFFFF0000;
    tick();
    reg_en = 1'b0; reg_wr_en = 1'b0;
    chk("ovr_addr_kept", 32'(dmi_req_addr), 32'h44);
    chk("ovr_wr_kept", 32'(dmi_req_wr), 32'd0);
    chk("ovr_status", 32'(op_status), 32'd3);
    accept(0, 1'b0, 7'h44, 32'h0);
    respond(2, 1'b0, 32'h33333333);
    chk("ovr_first_rd", rd_data, 32'h33333333);
    chk("ovr_status_kept", 32'(op_status), 32'd3);
    tick(); tick(); tick();
    chk("ovr_no_second_req", 32'(dmi_req_valid), 32'd0);
    chk("ovr_idle", 32'(busy), 32'd0);

    // clear and new error in the same cycle: new error loads
    start_req(1'b1, 7'h50, 32'h5);
    accept(0, 1'b1, 7'h50, 32'h5);
    dmi_rsp_valid = 1'b1; dmi_rsp_err = 1'b1; status_clr = 1'b1;
    tick();
    dmi_rsp_valid = 1'b0; dmi_rsp_err = 1'b0; status_clr = 1'b0;
    chk("clr_set_collide", 32'(op_status), 32'd2);
    pulse_clr();

    // reg_en on the cycle the FSM returns to IDLE is an overrun
    start_req(1'b0, 7'h60, 32'h0);
    accept(0, 1'b0, 7'h60, 32'h0);
    dmi_rsp_valid = 1'b1; dmi_rsp_rdata = 32'h44444444;
    reg_en = 1'b1; reg_addr = 7'h61;
    tick();
    dmi_rsp_valid = 1'b0; reg_en = 1'b0;
    chk("ret_ovr_busy", 32'(busy), 32'd0);
    chk("ret_ovr_status", 32'(op_status), 32'd3);
    chk("ret_ovr_rd", rd_data, 32'h44444444);
    tick();
    chk("ret_ovr_no_req", 32'(dmi_req_valid), 32'd0);
    pulse_clr();

`ifdef DMI_REQ_TIMEOUT_EN
    start_req(1'b0, 7'h70, 32'h0);
    accept(0, 1'b0, 7'h70, 32'h0);
    for (int i = 0; i < 14; i++) tick();
    chk("tmo_busy_cycle15", 32'(busy), 32'd1);
    tick();
    chk("tmo_idle", 32'(busy), 32'd0);
    chk("tmo_status", 32'(op_status), 32'd2);
    chk("tmo_rd", rd_data, 32'h44444444);
    pulse_clr();
    start_req(1'b0, 7'h71, 32'h0);
    accept(0, 1'b0, 7'h71, 32'h0);
    for (int i = 0; i < 14; i++) tick();
    dmi_rsp_valid = 1'b1; dmi_rsp_rdata = 32'h55555555;
    tick();
    dmi_rsp_valid = 1'b0;
    chk("tc_rsp_idle", 32'(busy), 32'd0);
    chk("tc_rsp_status", 32'(op_status), 32'd0);
    chk("tc_rsp_rd", rd_data, 32'h55555555);
`else
    start_req(1'b0, 7'h70, 32'h0);
    accept(0, 1'b0, 7'h70, 32'h0);
    for (int i = 0; i < 40; i++) tick();
    chk("no_tmo_still_busy", 32'(busy), 32'd1);
    chk("no_tmo_status", 32'(op_status), 32'd0);
    respond(1, 1'b0, 32'h55555555);
    chk("no_tmo_rd", rd_data, 32'h55555555);
`endif

    // reset mid-RSP abandons the transaction; late response ignored
    start_req(1'b0, 7'h12, 32'h0);
    accept(0, 1'b0, 7'h12, 32'h0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    dmi_rsp_valid = 1'b1; dmi_rsp_rdata = 32'h66666666;
    tick();
    dmi_rsp_valid = 1'b0;
    chk("rst_rsp_busy", 32'(busy), 32'd0);
    chk("rst_rsp_rd", rd_data, 32'd0);
    chk("rst_rsp_status", 32'(op_status), 32'd0);
    chk("rst_rsp_valid", 32'(dmi_req_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmi_core_req_ctrl.md
Name: dmi_core_req_ctrl

Overview:
- Core-clock stage directly downstream of the JTAG-to-core synchronizer.
- Consumes the single-cycle reg_en / reg_wr_en pulses together with the quasi-static JTAG address and write data.
- Issues one valid/ready request to the debug module, waits for its response, and holds the read data plus the sticky DMI op status for the JTAG side to capture.
- Busy is exported as a level so it can be synchronized back to TCK.

Parameters:
- ADDR_W, 7, DMI address width.
- DATA_W, 32, DMI data width.
- TIMEOUT_W, 8, response timeout counter width; timeout fires after 2^TIMEOUT_W-1 cycles in RSP.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- reg_en  in  1  one-cycle access pulse (read or write)
- reg_wr_en  in  1  one-cycle write qualifier, valid with reg_en
- reg_addr  in  ADDR_W  JTAG-domain address, stable while reg_en pulses
- reg_wdata  in  DATA_W  JTAG-domain write data, stable while reg_en pulses
- dmi_req_valid  out  1  request valid to debug module
- dmi_req_ready  in  1  debug module accepts request
- dmi_req_wr  out  1  1 = write, 0 = read
- dmi_req_addr  out  ADDR_W  request address
- dmi_req_wdata  out  DATA_W  request write data
- dmi_rsp_valid  in  1  one-cycle response strobe
- dmi_rsp_err  in  1  response error, valid with dmi_rsp_valid
- dmi_rsp_rdata  in  DATA_W  read data, valid with dmi_rsp_valid
- rd_data  out  DATA_W  last successful read data, held
- busy  out  1  high while state != IDLE
- op_status  out  2  sticky: 0 ok, 2 failed, 3 overrun/busy
- status_clr  in  1  one-cycle pulse (already synchronized), clears op_status

Behaviour:
- Reset: state IDLE; all outputs 0, including rd_data and op_status. Reset mid-transaction abandons it; a late dmi_rsp_valid after reset is ignored in IDLE.
- FSM states: IDLE, REQ, RSP.
- IDLE + reg_en:
  - Capture reg_addr, reg_wdata, reg_wr_en into the request registers.
  - Go to REQ; dmi_req_valid asserts the next cycle (1-cycle latency).
- REQ:
  - Hold valid, addr, wdata and wr stable until dmi_req_valid & dmi_req_ready; then go to RSP and drop valid.
  - dmi_rsp_valid in REQ is ignored. The debug module responds no earlier than the cycle after acceptance.
- RSP + dmi_rsp_valid:
  - dmi_rsp_err=0 and read: rd_data <= dmi_rsp_rdata.
  - dmi_rsp_err=0 and write: rd_data unchanged.
  - dmi_rsp_err=1: rd_data unchanged; op_status <= 2 if op_status==0.
  - In all three cases, go to IDLE.
- busy = (state != IDLE), registered-state derived, glitch-free.
- Overrun: reg_en while busy is ignored (the request is not captured); op_status <= 3 if op_status==0.
- op_status priority: first error wins until cleared. If status_clr and a new error occur in the same cycle, the new error code is loaded.
- reg_wr_en without reg_en is ignored.
- reg_en in the same cycle the FSM returns to IDLE counts as an overrun, because busy is still high that cycle.

Optional Feature:
- Macro DMI_REQ_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W counter clears on entry to RSP and increments each RSP cycle without a response.
  - At all-ones: go to IDLE; op_status <= 2 if 0; rd_data unchanged.
  - A response in the same cycle as the terminal count wins: it is treated as a normal response.
- Undefined: no counter; RSP waits indefinitely.

Decomposition:
- Shared package dmi_pkg holds:
  - state enum (IDLE/REQ/RSP);
  - op_status constants DMI_OP_OK=2'd0, DMI_OP_FAILED=2'd2, DMI_OP_BUSY=2'd3;
  - default widths.
- One natural sub-module: dmi_op_status_reg, the sticky status register with clear/set priority. Everything else stays flat.

Test Plan:
- Read: reg_en=1, reg_wr_en=0, reg_addr=7'h11; ready the same cycle req_valid rises; rsp 3 cycles later with rdata=32'hDEADBEEF, err=0 -> dmi_req_wr=0, addr=7'h11, rd_data=32'hDEADBEEF, op_status=0, busy low 1 cycle after the rsp strobe.
- Write with backpressure: reg_wdata=32'h0000_0001, addr=7'h10, ready held low 5 cycles -> req_valid, addr and wdata stable for 6 cycles; after rsp, rd_data is unchanged from its prior value.
- Error then clear: rsp err=1 -> op_status=2. A second err with status=2 -> stays 2. status_clr pulse -> 0.
- Overrun: second reg_en 2 cycles into REQ -> no second request issued, op_status=3. First transaction still completes normally.
- Reset mid-RSP: assert rst_n=0 during RSP, release, then send rsp_valid -> state IDLE, rd_data=0, busy=0, no update.
- With DMI_REQ_TIMEOUT_EN, TIMEOUT_W=4, no rsp -> return to IDLE after 15 RSP cycles, op_status=2. A rsp on cycle 15 -> normal completion, op_status=0.
